encode_frame_pack: RTL and testbench

- Downstream consumer of the aligned PMT encoder stream (encode enable plus 18-bit W and 18-bit X samples).
- Frames each PMT scan window into a 32-bit word stream: header, then two words per sample, then a trailer.
- Samples pass through a small register FIFO. Output uses a valid/ready handshake toward the upload/DDR path.
- Absorbs short back-pressure and reports loss explicitly.

---
 rtl/encode_frame_pack_if.sv | 21 ++
 rtl/encode_frame_pack.sv | 195 +++++++++++++++++++
 tb/tb_encode_frame_pack.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/encode_frame_pack_if.sv
// rtl/encode_frame_pack_if.sv - output word stream bundle for encode_frame_pack
interface encode_frame_pack_if;
    logic [31:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        m_last_o;

    modport master (
        output m_data_o,
        output m_valid_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o,
        output m_ready_i
    );
endinterface

// File: rtl/encode_frame_pack.sv
// rtl/encode_frame_pack.sv - frames PMT encoder samples into a 32-bit word stream; ENCODE_PACK_DECIM_EN adds per-frame sample decimation
module encode_frame_pack #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] HDR_TAG    = 16'hA5C3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                scan_en_i,
    input  logic                encode_en_i,
    input  logic [17:0]         encode_w_i,
    input  logic [17:0]         encode_x_i,
    input  logic [7:0]          decim_i,
    encode_frame_pack_if.master m_if,
    output logic                overflow_o,
    output logic                start_err_o,
    output logic [15:0]         frame_seq_o
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_DATA_W, S_DATA_X, S_TAIL} state_t;

    state_t        state_q, state_d;
    logic          scan_en_q, scan_en_d;
    logic          cap_active_q, cap_active_d;
    logic          start_err_q, start_err_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   seq_q, seq_d;
    logic [26:0]   cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [35:0]   mem_q [FIFO_DEPTH];
    logic [35:0]   head_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d, last_q, last_d;
    logic          rise, fall, frame_open, cap_eff, fifo_full, fifo_empty;
    logic          hs, pop, push, drop, eligible;

`ifdef ENCODE_PACK_DECIM_EN
    logic [7:0]    phase_q, phase_d, decim_q, decim_d;
`else
    logic          unused_decim;
    assign unused_decim = ^decim_i;
`endif

    // Scan edge detect and per-cycle capture / FIFO push-pop decisions
    always_comb begin
        rise       = scan_en_i & ~scan_en_q;
        fall       = ~scan_en_i & scan_en_q;
        frame_open = rise & (state_q == S_IDLE);
        // the fall cycle itself no longer belongs to the window
        cap_eff    = cap_active_q & ~fall;
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        hs         = valid_q & m_if.m_ready_i;
        pop        = hs & (state_q == S_DATA_X);
`ifdef ENCODE_PACK_DECIM_EN
        eligible   = (phase_q == 8'd0);
`else
        eligible   = 1'b1;
`endif
        // a pop in the same cycle frees the slot for a push at full
        push       = encode_en_i & cap_eff & eligible & (~fifo_full | pop);
        drop       = encode_en_i & cap_eff & eligible & fifo_full & ~pop;
    end

    // Next-state logic for the frame sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (frame_open) state_d = S_HEAD;
            S_HEAD:   if (hs) state_d = S_DATA_W;
            S_DATA_W: begin
                if (!fifo_empty) begin
                    if (hs) state_d = S_DATA_X;
                end else if (!cap_active_q) begin
                    state_d = S_TAIL;
                end
            end
            S_DATA_X: if (hs) state_d = S_DATA_W;
            S_TAIL:   if (hs) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Frame bookkeeping, flags and FIFO pointer updates
    always_comb begin
        scan_en_d    = scan_en_i;
        cap_active_d = frame_open ? 1'b1 : (fall ? 1'b0 : cap_active_q);
        start_err_d  = start_err_q | (rise & (state_q != S_IDLE));
        seq_d        = frame_open ? seq_q + 16'd1 : seq_q;
        overflow_d   = frame_open ? 1'b0 : (overflow_q | drop);
        cnt_d        = cnt_q;
        if (frame_open)                 cnt_d = '0;
        else if (push && cnt_q != '1)   cnt_d = cnt_q + 27'd1;
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d      = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
`ifdef ENCODE_PACK_DECIM_EN
        decim_d = frame_open ? decim_i : decim_q;
        phase_d = phase_q;
        if (frame_open)                 phase_d = 8'd0;
        else if (encode_en_i && cap_eff) phase_d = (phase_q == decim_q) ? 8'd0 : phase_q + 8'd1;
`endif
    end

    // Output word for the state being entered, so data/last come straight from flops
    always_comb begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = '0;
        // an entry written this cycle is not in mem_q yet, so bypass it when it becomes the head
        head_d  = (push && (rd_ptr_d == wr_ptr_q)) ? {encode_w_i, encode_x_i} : mem_q[rd_ptr_d];
        case (state_d)
            S_HEAD: begin
                valid_d = 1'b1;
                data_d  = {HDR_TAG, seq_d};
            end
            S_DATA_W: begin
                valid_d = (count_d != '0);
                data_d  = {4'h1, 10'd0, head_d[35:18]};
            end
            S_DATA_X: begin
                valid_d = (count_d != '0);
                data_d  = {4'h2, 10'd0, head_d[17:0]};
            end
            S_TAIL: begin
                valid_d = 1'b1;
                last_d  = 1'b1;
                data_d  = {4'hF, overflow_d, cnt_d};
            end
            default: ;
        endcase
    end

    // Frame sequencer state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath, flag and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scan_en_q    <= 1'b0;
            cap_active_q <= 1'b0;
            start_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            seq_q        <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
`ifdef ENCODE_PACK_DECIM_EN
            phase_q      <= '0;
            decim_q      <= '0;
`endif
        end else begin
            scan_en_q    <= scan_en_d;
            cap_active_q <= cap_active_d;
            start_err_q  <= start_err_d;
            overflow_q   <= overflow_d;
            seq_q        <= seq_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
`ifdef ENCODE_PACK_DECIM_EN
            phase_q      <= phase_d;
            decim_q      <= decim_d;
`endif
        end
    end

    // Sample storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {encode_w_i, encode_x_i};
    end

    assign m_if.m_data_o  = data_q;
    assign m_if.m_valid_o = valid_q;
    assign m_if.m_last_o  = last_q;
    assign overflow_o     = overflow_q;
    assign start_err_o    = start_err_q;
    assign frame_seq_o    = seq_q;
endmodule

// File: tb/tb_encode_frame_pack.sv
// tb/tb_encode_frame_pack.sv - self-checking bench for encode_frame_pack
module tb_encode_frame_pack;
    logic        clk = 1'b0;
    logic        rst, scan_en, encode_en, ready;
    logic [17:0] w, x;
    logic [7:0]  decim;
    logic        overflow, start_err;
    logic [15:0] frame_seq;

    always #5 clk = ~clk;

    encode_frame_pack_if m_if();
    assign m_if.m_ready_i = ready;

    encode_frame_pack #(.FIFO_DEPTH(16), .HDR_TAG(16'hA5C3)) dut (
        .clk_i(clk), .rst_i(rst), .scan_en_i(scan_en), .encode_en_i(encode_en),
        .encode_w_i(w), .encode_x_i(x), .decim_i(decim), .m_if(m_if),
        .overflow_o(overflow), .start_err_o(start_err), .frame_seq_o(frame_seq)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] got[$];
    int          n_last  = 0;
    logic [35:0] offered[$];
    logic [15:0] exp_seq = '0;
    bit          rnd_ready = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = '0;

    typedef struct {
        int          n;
        logic [17:0] w0;
        logic [17:0] x0;
        int          gap;
        bit          junk;
        int          exp_words;
        logic [31:0] exp_trailer;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) ready = 1'($urandom_range(0, 1));
    endtask

    // Word collector and hold-while-stalled check, sampled away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(m_if.m_valid_o), 32'd1);
                check("hold_data", m_if.m_data_o, prev_data);
            end
            stall_prev = m_if.m_valid_o & ~ready;
            prev_data  = m_if.m_data_o;
            if (m_if.m_valid_o && ready) begin
                got.push_back(m_if.m_data_o);
                if (m_if.m_last_o) n_last++;
            end
        end
    end

    task automatic drive_window(input int n, input logic [17:0] w0, input logic [17:0] x0,
                                input int gap, input bit junk);
        offered.delete();
        got.delete();
        n_last  = 0;
        scan_en = 1'b1;
        if (junk) begin encode_en = 1'b1; w = 18'h3ABCD; x = 18'h15555; end
        tick();
        encode_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            encode_en = 1'b1;
            w = w0 + 18'(i);
            x = x0 + 18'(i);
            offered.push_back({w, x});
            tick();
            encode_en = 1'b0;
            repeat (gap) tick();
        end
        scan_en = 1'b0;
        if (junk) begin encode_en = 1'b1; w = 18'h2F0F0; x = 18'h0F0F0; end
        tick();
        encode_en = 1'b0;
    endtask

    task automatic wait_last();
        int k = 0;
        while (n_last == 0 && k < 400) begin
            tick();
            k++;
        end
        check("drain_timeout", 32'(n_last != 0), 32'd1);
    endtask

    // Reference: header, then the kept samples as W/X pairs, then a trailer with the kept count
    task automatic check_frame(input int max_keep, input logic exp_ovf);
        logic [35:0] kept[$];
        logic [31:0] exp_w[$];
        int          nchk;
        foreach (offered[i]) begin
`ifdef ENCODE_PACK_DECIM_EN
            if (i % (int'(decim) + 1) == 0)
`endif
                kept.push_back(offered[i]);
        end
        while (kept.size() > max_keep) void'(kept.pop_back());
        exp_w.push_back({16'hA5C3, exp_seq});
        foreach (kept[i]) begin
            exp_w.push_back({4'h1, 10'd0, kept[i][35:18]});
            exp_w.push_back({4'h2, 10'd0, kept[i][17:0]});
        end
        exp_w.push_back({4'hF, exp_ovf, 27'(kept.size())});
        check("word_count", 32'(got.size()), 32'(exp_w.size()));
        nchk = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
        for (int i = 0; i < nchk; i++) check($sformatf("word%0d", i), got[i], exp_w[i]);
        check("last_count", 32'(n_last), 32'd1);
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("frame_seq", 32'(frame_seq), 32'(exp_seq));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int len;
        vecs[0] = '{3, 18'd1,      18'h10,    0, 1'b0, 8,  32'hF0000003};
        vecs[1] = '{0, 18'd0,      18'd0,     0, 1'b1, 2,  32'hF0000000};
        vecs[2] = '{5, 18'h3FFF0,  18'h2AAAA, 1, 1'b1, 12, 32'hF0000005};
        vecs[3] = '{1, 18'h3FFFF,  18'h00000, 3, 1'b0, 4,  32'hF0000001};

        rst = 1'b1; scan_en = 1'b0; encode_en = 1'b0; w = '0; x = '0; decim = '0; ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_valid", 32'(m_if.m_valid_o), 32'd0);
        check("rst_data", m_if.m_data_o, 32'd0);
        check("rst_last", 32'(m_if.m_last_o), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_start_err", 32'(start_err), 32'd0);
        check("rst_frame_seq", 32'(frame_seq), 32'd0);

        ready = 1'b1;
        foreach (vecs[v]) begin
            drive_window(vecs[v].n, vecs[v].w0, vecs[v].x0, vecs[v].gap, vecs[v].junk);
            exp_seq++;
            wait_last();
            check_frame(1000, 1'b0);
            check("table_words", 32'(got.size()), 32'(vecs[v].exp_words));
            if (got.size() > 0) check("table_trailer", got[got.size()-1], vecs[v].exp_trailer);
        end

        // back-pressure overflow: 20 samples into a 16-deep FIFO
        ready = 1'b0;
        drive_window(20, 18'h100, 18'h200, 0, 1'b0);
        exp_seq++;
        ready = 1'b1;
        wait_last();
        check_frame(16, 1'b1);
        if (got.size() > 0) check("ovf_trailer", got[got.size()-1], 32'hF8000010);

        // overflow clears on the next accepted frame open
        offered.delete(); got.delete(); n_last = 0;
        scan_en = 1'b1;
        tick();
        exp_seq++;
        check("ovf_clear", 32'(overflow), 32'd0);
        scan_en = 1'b0;
        tick();
        wait_last();
        check_frame(1000, 1'b0);

        // random ready, sparse random samples
        rnd_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            offered.delete(); got.delete(); n_last = 0;
            scan_en = 1'b1;
            tick();
            len = $urandom_range(20, 80);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    encode_en = 1'b1;
                    w = 18'($urandom);
                    x = 18'($urandom);
                    offered.push_back({w, x});
                end
                tick();
                encode_en = 1'b0;
            end
            scan_en = 1'b0;
            tick();
            exp_seq++;
            wait_last();
            check_frame(1000, 1'b0);
        end
        rnd_ready = 1'b0;

        // second rise while the trailer is stalled
        offered.delete(); got.delete(); n_last = 0;
        ready = 1'b0;
        scan_en = 1'b1;
        tick();
        exp_seq++;
        scan_en = 1'b0;
        tick();
        ready = 1'b1;
        k = 0;
        while (got.size() < 1 && k < 20) begin tick(); k++; end
        ready = 1'b0;
        repeat (3) tick();
        check("tail_valid", 32'(m_if.m_valid_o), 32'd1);
        check("tail_last", 32'(m_if.m_last_o), 32'd1);
        scan_en = 1'b1;
        tick();
        scan_en = 1'b0;
        tick();
        check("start_err_set", 32'(start_err), 32'd1);
        check("seq_unchanged", 32'(frame_seq), 32'(exp_seq));
        ready = 1'b1;
        wait_last();
        repeat (10) tick();
        check("no_new_header", 32'(got.size()), 32'd2);
        if (got.size() > 1) check("err_trailer", got[1], 32'hF0000000);
        check("seq_after_err", 32'(frame_seq), 32'(exp_seq));
        check("start_err_sticky", 32'(start_err), 32'd1);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_seq = '0;
        tick();
        check("start_err_rst", 32'(start_err), 32'd0);
        check("seq_rst", 32'(frame_seq), 32'd0);

        // decimation: 1 of 4 kept only when the feature is built in
        decim = 8'd3;
        ready = 1'b1;
        drive_window(12, 18'h40, 18'h80, 0, 1'b0);
        exp_seq++;
        wait_last();
        check_frame(1000, 1'b0);
`ifdef ENCODE_PACK_DECIM_EN
        if (got.size() > 0) check("decim_trailer", got[got.size()-1], 32'hF0000003);
`else
        if (got.size() > 0) check("decim_trailer", got[got.size()-1], 32'hF000000C);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
